// File: rtl/icms_pkg.sv
// +----------------------------------------------------------------------------+
// | icms_pkg : shared encodings for the runway arbiter and ECSU display decode  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package icms_pkg;

  localparam int c_ID_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_LANDING = 2'b01,
    ARB_TAKEOFF = 2'b10
  } arb_state_e;

  // Environmental control stage states, decoded by the cockpit/ATC display
  typedef enum logic [1:0] {
    ECSU_NORMAL    = 2'b00,
    ECSU_CAUTION   = 2'b01,
    ECSU_SEVERE    = 2'b10,
    ECSU_EMERGENCY = 2'b11
  } ecsu_state_e;

endpackage

`default_nettype wire

// File: rtl/req_fifo.sv
// +----------------------------------------------------------------------------+
// | req_fifo : request queue with push/pop/flush, count, flags and head data   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module req_fifo
  import icms_pkg::*;
#(
  parameter int WIDTH = c_ID_W_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  // Full is judged before any same-edge pop, so a push into a full queue is lost
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/runway_traffic_arbiter.sv
// +----------------------------------------------------------------------------+
// | runway_traffic_arbiter : landing-priority single-runway grant arbiter      |
// | Optional statistics outputs enabled by macro ARBITER_STATS_EN              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module runway_traffic_arbiter
  import icms_pkg::*;
#(
  parameter int ID_W           = c_ID_W_DEFAULT,
  parameter int QDEPTH         = 4,
  parameter int LAND_CYCLES    = 5,
  parameter int TAKEOFF_CYCLES = 3,
  parameter int CNT_W          = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             land_req,
  input  logic [ID_W-1:0]  land_id,
  input  logic             takeoff_req,
  input  logic [ID_W-1:0]  takeoff_id,
  input  logic             severe_weather,
  input  logic             emergency_landing_alert,
  output logic             grant_valid,
  output logic             grant_is_landing,
  output logic [ID_W-1:0]  grant_id,
  output logic             runway_busy,
  output logic [CNT_W-1:0] land_q_count,
  output logic [CNT_W-1:0] takeoff_q_count,
  output logic             reject,
  output logic [1:0]       arb_state
`ifdef ARBITER_STATS_EN
  ,
  output logic [7:0]       total_landings,
  output logic [7:0]       total_takeoffs
`endif
);

  localparam int c_MAX_CYC = (LAND_CYCLES > TAKEOFF_CYCLES) ? LAND_CYCLES : TAKEOFF_CYCLES;
  localparam int c_TIMER_W = $clog2(c_MAX_CYC);

  arb_state_e           r_state, w_state_nx;
  logic [c_TIMER_W-1:0] r_timer, w_timer_nx;
  logic                 r_grant_valid, w_grant_valid_nx;
  logic                 r_grant_is_landing, w_grant_is_landing_nx;
  logic [ID_W-1:0]      r_grant_id, w_grant_id_nx;
  logic                 r_busy;
  logic                 r_reject;
  logic                 w_land_pop, w_to_pop;
  logic                 w_land_full, w_land_empty, w_to_full, w_to_empty;
  logic [ID_W-1:0]      w_land_head, w_to_head;
  logic                 w_land_rej, w_to_rej;

  assign w_land_rej = land_req && w_land_full;
  assign w_to_rej   = takeoff_req && (w_to_full || emergency_landing_alert);

  req_fifo #(.WIDTH(ID_W), .DEPTH(QDEPTH), .CNT_W(CNT_W)) u_land_q (
    .CLK(CLK), .RST(RST),
    .push(land_req), .push_data(land_id), .pop(w_land_pop), .flush(1'b0),
    .count(land_q_count), .full(w_land_full), .empty(w_land_empty), .head(w_land_head)
  );

  // Emergency flushes queued takeoffs every edge and blocks new ones
  req_fifo #(.WIDTH(ID_W), .DEPTH(QDEPTH), .CNT_W(CNT_W)) u_takeoff_q (
    .CLK(CLK), .RST(RST),
    .push(takeoff_req && !emergency_landing_alert), .push_data(takeoff_id),
    .pop(w_to_pop), .flush(emergency_landing_alert),
    .count(takeoff_q_count), .full(w_to_full), .empty(w_to_empty), .head(w_to_head)
  );

  always_comb begin
    w_state_nx            = r_state;
    w_timer_nx            = r_timer;
    w_grant_valid_nx      = 1'b0;
    w_grant_is_landing_nx = 1'b0;
    w_grant_id_nx         = '0;
    w_land_pop            = 1'b0;
    w_to_pop              = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (!w_land_empty) begin
          w_land_pop            = 1'b1;
          w_grant_valid_nx      = 1'b1;
          w_grant_is_landing_nx = 1'b1;
          w_grant_id_nx         = w_land_head;
          w_state_nx            = ARB_LANDING;
          w_timer_nx            = c_TIMER_W'(LAND_CYCLES - 1);
        end else if (!w_to_empty && !severe_weather && !emergency_landing_alert) begin
          w_to_pop         = 1'b1;
          w_grant_valid_nx = 1'b1;
          w_grant_id_nx    = w_to_head;
          w_state_nx       = ARB_TAKEOFF;
          w_timer_nx       = c_TIMER_W'(TAKEOFF_CYCLES - 1);
        end
      end
      ARB_LANDING, ARB_TAKEOFF: begin
        if (r_timer == '0) w_state_nx = ARB_IDLE;
        else               w_timer_nx = r_timer - c_TIMER_W'(1);
      end
      default: w_state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state            <= ARB_IDLE;
      r_timer            <= '0;
      r_grant_valid      <= 1'b0;
      r_grant_is_landing <= 1'b0;
      r_grant_id         <= '0;
      r_busy             <= 1'b0;
      r_reject           <= 1'b0;
    end else begin
      r_state            <= w_state_nx;
      r_timer            <= w_timer_nx;
      r_grant_valid      <= w_grant_valid_nx;
      r_grant_is_landing <= w_grant_is_landing_nx;
      r_grant_id         <= w_grant_id_nx;
      r_busy             <= (w_state_nx != ARB_IDLE);
      r_reject           <= w_land_rej || w_to_rej;
    end
  end

  assign grant_valid      = r_grant_valid;
  assign grant_is_landing = r_grant_is_landing;
  assign grant_id         = r_grant_id;
  assign runway_busy      = r_busy;
  assign reject           = r_reject;
  assign arb_state        = r_state;

`ifdef ARBITER_STATS_EN
  logic [7:0] r_total_landings;
  logic [7:0] r_total_takeoffs;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_total_landings <= '0;
      r_total_takeoffs <= '0;
    end else begin
      if (w_grant_valid_nx && w_grant_is_landing_nx && (r_total_landings != 8'hFF))
        r_total_landings <= r_total_landings + 8'd1;
      if (w_grant_valid_nx && !w_grant_is_landing_nx && (r_total_takeoffs != 8'hFF))
        r_total_takeoffs <= r_total_takeoffs + 8'd1;
    end
  end

  assign total_landings = r_total_landings;
  assign total_takeoffs = r_total_takeoffs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_runway_traffic_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_runway_traffic_arbiter : scoreboard bench for runway_traffic_arbiter    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_runway_traffic_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       land_req = 1'b0;
  logic [3:0] land_id = '0;
  logic       takeoff_req = 1'b0;
  logic [3:0] takeoff_id = '0;
  logic       severe_weather = 1'b0;
  logic       emergency_landing_alert = 1'b0;
  logic       grant_valid;
  logic       grant_is_landing;
  logic [3:0] grant_id;
  logic       runway_busy;
  logic [2:0] land_q_count;
  logic [2:0] takeoff_q_count;
  logic       reject;
  logic [1:0] arb_state;
`ifdef ARBITER_STATS_EN
  logic [7:0] total_landings;
  logic [7:0] total_takeoffs;
`endif

  typedef struct packed {
    logic       land;
    logic [3:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  runway_traffic_arbiter dut (
    .CLK(CLK), .RST(RST),
    .land_req(land_req), .land_id(land_id),
    .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
    .severe_weather(severe_weather), .emergency_landing_alert(emergency_landing_alert),
    .grant_valid(grant_valid), .grant_is_landing(grant_is_landing), .grant_id(grant_id),
    .runway_busy(runway_busy), .land_q_count(land_q_count), .takeoff_q_count(takeoff_q_count),
    .reject(reject), .arb_state(arb_state)
`ifdef ARBITER_STATS_EN
    , .total_landings(total_landings), .total_takeoffs(total_takeoffs)
`endif
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every grant pulse is matched against the next expected grant
  always @(posedge CLK) begin
    exp_t e;
    cyc++;
    #1;
    if (!RST && grant_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got land=%0b id=%0d, required no grant", grant_is_landing, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (grant_is_landing !== e.land || grant_id !== e.id) begin
          errors++;
          $display("FAIL grant_order: got land=%0b id=%0d, required land=%0b id=%0d",
                   grant_is_landing, grant_id, e.land, e.id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL grant_timeout: got no grant in 40 cycles, required a grant");
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (arb_state === 2'b00 && runway_busy === 1'b0 && land_q_count === 3'd0 && takeoff_q_count === 3'd0) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got state=%0d lq=%0d tq=%0d, required idle and empty",
               arb_state, land_q_count, takeoff_q_count);
    end
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({grant_valid, grant_is_landing, grant_id, runway_busy, land_q_count,
         takeoff_q_count, reject, arb_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gv=%0b gl=%0b id=%0d busy=%0b lq=%0d tq=%0d rej=%0b st=%0d, required all 0",
               grant_valid, grant_is_landing, grant_id, runway_busy, land_q_count, takeoff_q_count, reject, arb_state);
    end
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_single_landing();
    int at;
    land_req = 1'b1; land_id = 4'd3; exp_q.push_back('{1'b1, 4'd3});
    tick();
    land_req = 1'b0;
    checks++;
    if (land_q_count !== 3'd1 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL land_push: got lq=%0d gv=%0b, required lq=1 gv=0", land_q_count, grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || runway_busy !== 1'b1 || arb_state !== 2'b01 || land_q_count !== 3'd0) begin
      errors++;
      $display("FAIL land_grant: got gv=%0b busy=%0b st=%0d lq=%0d, required 1 1 1 0",
               grant_valid, runway_busy, arb_state, land_q_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (runway_busy !== 1'b1 || arb_state !== 2'b01 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL land_busy: cycle %0d got busy=%0b st=%0d gv=%0b, required 1 1 0",
                 i + 2, runway_busy, arb_state, grant_valid);
      end
    end
    tick();
    checks++;
    if (runway_busy !== 1'b0 || arb_state !== 2'b00) begin
      errors++;
      $display("FAIL land_release: got busy=%0b st=%0d, required 0 0", runway_busy, arb_state);
    end
    wait_idle();
  endtask

  task automatic test_priority();
    int at1, at2;
    land_req = 1'b1; land_id = 4'd9;
    takeoff_req = 1'b1; takeoff_id = 4'd7;
    exp_q.push_back('{1'b1, 4'd9});
    exp_q.push_back('{1'b0, 4'd7});
    tick();
    land_req = 1'b0; takeoff_req = 1'b0;
    checks++;
    if (land_q_count !== 3'd1 || takeoff_q_count !== 3'd1 || reject !== 1'b0) begin
      errors++;
      $display("FAIL dual_push: got lq=%0d tq=%0d rej=%0b, required 1 1 0", land_q_count, takeoff_q_count, reject);
    end
    wait_grant(at1);
    wait_grant(at2);
    checks++;
    if (at2 - at1 !== 6) begin
      errors++;
      $display("FAIL grant_spacing: got %0d cycles, required 6", at2 - at1);
    end
    checks++;
    if (arb_state !== 2'b10) begin
      errors++;
      $display("FAIL takeoff_state: got st=%0d, required 2", arb_state);
    end
    wait_idle();
  endtask

  task automatic test_weather_hold();
    severe_weather = 1'b1;
    takeoff_req = 1'b1; takeoff_id = 4'd2; exp_q.push_back('{1'b0, 4'd2});
    tick();
    takeoff_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (takeoff_q_count !== 3'd1 || grant_valid !== 1'b0 || reject !== 1'b0 || arb_state !== 2'b00) begin
        errors++;
        $display("FAIL weather_hold: got tq=%0d gv=%0b rej=%0b st=%0d, required 1 0 0 0",
                 takeoff_q_count, grant_valid, reject, arb_state);
      end
    end
    severe_weather = 1'b0;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_is_landing !== 1'b0 || takeoff_q_count !== 3'd0) begin
      errors++;
      $display("FAIL weather_release: got gv=%0b gl=%0b tq=%0d, required 1 0 0",
               grant_valid, grant_is_landing, takeoff_q_count);
    end
    wait_idle();
  endtask

  task automatic test_queue_full();
    logic [3:0] ids [5] = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd10};
    land_req = 1'b1; land_id = 4'd1; exp_q.push_back('{1'b1, 4'd1});
    tick();
    land_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      land_req = 1'b1; land_id = ids[i];
      if (i < 4) exp_q.push_back('{1'b1, ids[i]});
      tick();
      checks++;
      if (reject !== (i == 4)) begin
        errors++;
        $display("FAIL full_reject: push %0d got rej=%0b, required %0b", i, reject, i == 4);
      end
    end
    land_req = 1'b0;
    checks++;
    if (land_q_count !== 3'd4) begin
      errors++;
      $display("FAIL full_count: got lq=%0d, required 4", land_q_count);
    end
    tick();
    checks++;
    if (reject !== 1'b0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: got rej=%0b gv=%0b, required 0 1", reject, grant_valid);
    end
    wait_idle();
  endtask

  task automatic test_emergency();
    int at;
    severe_weather = 1'b1;
    takeoff_req = 1'b1; takeoff_id = 4'd11;
    tick();
    takeoff_id = 4'd12;
    tick();
    takeoff_req = 1'b0;
    checks++;
    if (takeoff_q_count !== 3'd2) begin
      errors++;
      $display("FAIL emg_setup: got tq=%0d, required 2", takeoff_q_count);
    end
    emergency_landing_alert = 1'b1;
    tick();
    checks++;
    if (takeoff_q_count !== 3'd0 || reject !== 1'b0) begin
      errors++;
      $display("FAIL emg_flush: got tq=%0d rej=%0b, required 0 0", takeoff_q_count, reject);
    end
    takeoff_req = 1'b1; takeoff_id = 4'd13;
    tick();
    takeoff_req = 1'b0;
    checks++;
    if (reject !== 1'b1 || takeoff_q_count !== 3'd0) begin
      errors++;
      $display("FAIL emg_reject: got rej=%0b tq=%0d, required 1 0", reject, takeoff_q_count);
    end
    land_req = 1'b1; land_id = 4'd14; exp_q.push_back('{1'b1, 4'd14});
    tick();
    land_req = 1'b0;
    checks++;
    if (reject !== 1'b0) begin
      errors++;
      $display("FAIL emg_reject_pulse: got rej=%0b, required 0", reject);
    end
    wait_grant(at);
    emergency_landing_alert = 1'b0;
    severe_weather = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_op();
    takeoff_req = 1'b1; takeoff_id = 4'd5; exp_q.push_back('{1'b0, 4'd5});
    tick();
    takeoff_req = 1'b0;
    tick();
    land_req = 1'b1; land_id = 4'd6;
    tick();
    land_id = 4'd7;
    tick();
    land_req = 1'b0;
    checks++;
    if (arb_state !== 2'b10 || land_q_count !== 3'd2) begin
      errors++;
      $display("FAIL rst_setup: got st=%0d lq=%0d, required 2 2", arb_state, land_q_count);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({grant_valid, grant_is_landing, grant_id, runway_busy, land_q_count,
         takeoff_q_count, reject, arb_state} !== '0) begin
      errors++;
      $display("FAIL rst_async: got busy=%0b lq=%0d tq=%0d st=%0d, required all 0",
               runway_busy, land_q_count, takeoff_q_count, arb_state);
    end
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b0 || runway_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_grant: got gv=%0b busy=%0b, required 0 0", grant_valid, runway_busy);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_landing();
    test_priority();
    test_weather_hold();
    test_queue_full();
    test_emergency();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending grants, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
